// File: rtl/sort4_ctrl.sv
// Sequenced four-entry sorter: a fixed six-step compare-exchange schedule
// run through one shared magnitude comparator, one comparison per clock.
module sort4_ctrl #(
    parameter int WIDTH   = 4,
    parameter bit DESCEND = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*WIDTH-1:0]   din,
    output logic [4*WIDTH-1:0]   dout,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           swap_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r, state_next_s;
    logic [2:0]          step_r, step_next_s;
    logic [2:0]          cnt_r, cnt_next_s;
    logic [WIDTH-1:0]    elem_r      [4];
    logic [WIDTH-1:0]    elem_next_s [4];
    logic                busy_r, done_r;
    logic [1:0]          pair_s;
    logic [WIDTH-1:0]    a_s, b_s;
    logic [1:0]          cmp_s;
    logic                swap_s;

    // Schedule (0,1),(1,2),(2,3),(0,1),(1,2),(0,1): lower index of each pair.
    function automatic logic [1:0] pair_of(input logic [2:0] step);
        case (step)
            3'd0:    pair_of = 2'd0;
            3'd1:    pair_of = 2'd1;
            3'd2:    pair_of = 2'd2;
            3'd3:    pair_of = 2'd0;
            3'd4:    pair_of = 2'd1;
            3'd5:    pair_of = 2'd0;
            default: pair_of = 2'd0;
        endcase
    endfunction

    // The single shared unsigned comparator: {greater, lesser}.
    function automatic logic [1:0] mag_cmp(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        mag_cmp = {(a > b), (a < b)};
    endfunction

    assign pair_s = pair_of(step_r);
    assign a_s    = elem_r[pair_s];
    assign b_s    = elem_r[pair_s + 2'd1];
    assign cmp_s  = mag_cmp(a_s, b_s);
    // Equal operands give neither flag, so equal values never move.
    assign swap_s = DESCEND ? cmp_s[0] : cmp_s[1];

    // Next-state, working-register and swap-count logic.
    always_comb begin
        state_next_s = state_r;
        step_next_s  = step_r;
        cnt_next_s   = cnt_r;
        for (int i = 0; i < 4; i++) begin
            elem_next_s[i] = elem_r[i];
        end
        case (state_r)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 4; i++) begin
                        elem_next_s[i] = din[i*WIDTH +: WIDTH];
                    end
                    step_next_s  = 3'd0;
                    cnt_next_s   = 3'd0;
                    state_next_s = CMP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CMP: begin
                if (swap_s) begin
                    elem_next_s[pair_s]        = b_s;
                    elem_next_s[pair_s + 2'd1] = a_s;
                    cnt_next_s                 = cnt_r + 3'd1;
                end else begin
                    cnt_next_s = cnt_r;
                end
                if (step_r == 3'd5) begin
                    state_next_s = DONE;
                end else begin
                    step_next_s = step_r + 3'd1;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, working registers and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            step_r  <= 3'd0;
            cnt_r   <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                elem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_r <= state_next_s;
            step_r  <= step_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == DONE);
            for (int i = 0; i < 4; i++) begin
                elem_r[i] <= elem_next_s[i];
            end
        end
    end

    assign dout     = {elem_r[3], elem_r[2], elem_r[1], elem_r[0]};
    assign busy     = busy_r;
    assign done     = done_r;
    assign swap_cnt = cnt_r;

endmodule

// File: tb/tb_sort4_ctrl.sv
// Directed bench for sort4_ctrl: ascending and descending instances, timing
// of busy/done, start-while-busy rejection and asynchronous reset mid-sort.
module tb_sort4_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_d = 1'b0;
    logic [15:0] din_a = 16'h0000, din_d = 16'h0000;
    logic [15:0] dout_a, dout_d;
    logic        busy_a, busy_d, done_a, done_d;
    logic [2:0]  swap_a, swap_d;
    int          vectors = 0;
    int          miscompares = 0;

    sort4_ctrl #(.WIDTH(4), .DESCEND(1'b0)) dut_asc (
        .clk(clk), .rst_n(rst_n), .start(start_a), .din(din_a),
        .dout(dout_a), .busy(busy_a), .done(done_a), .swap_cnt(swap_a)
    );

    sort4_ctrl #(.WIDTH(4), .DESCEND(1'b1)) dut_desc (
        .clk(clk), .rst_n(rst_n), .start(start_d), .din(din_d),
        .dout(dout_d), .busy(busy_d), .done(done_d), .swap_cnt(swap_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One full sort on the selected instance, checking every cycle 1..8.
    task automatic do_sort(input bit sel, input string tag, input logic [15:0] d,
                           input logic [15:0] exp, input logic [2:0] exp_swaps);
        if (sel) begin start_d = 1'b1; din_d = d; end
        else     begin start_a = 1'b1; din_a = d; end
        next_cycle();
        start_a = 1'b0;
        start_d = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check({tag, "_busy_cmp"}, {15'd0, sel ? busy_d : busy_a}, 16'd1);
            check({tag, "_done_cmp"}, {15'd0, sel ? done_d : done_a}, 16'd0);
            next_cycle();
        end
        check({tag, "_done"},  {15'd0, sel ? done_d : done_a}, 16'd1);
        check({tag, "_busy7"}, {15'd0, sel ? busy_d : busy_a}, 16'd1);
        check({tag, "_dout"},  sel ? dout_d : dout_a, exp);
        check({tag, "_swaps"}, {13'd0, sel ? swap_d : swap_a}, {13'd0, exp_swaps});
        next_cycle();
        check({tag, "_done8"}, {15'd0, sel ? done_d : done_a}, 16'd0);
        check({tag, "_busy8"}, {15'd0, sel ? busy_d : busy_a}, 16'd0);
        check({tag, "_hold"},  sel ? dout_d : dout_a, exp);
        check({tag, "_hold_swaps"}, {13'd0, sel ? swap_d : swap_a}, {13'd0, exp_swaps});
    endtask

    initial begin
        #12;
        check("rst_dout", dout_a, 16'h0000);
        check("rst_busy", {15'd0, busy_a}, 16'd0);
        check("rst_done", {15'd0, done_a}, 16'd0);
        check("rst_swaps", {13'd0, swap_a}, 16'd0);
        rst_n = 1'b1;
        next_cycle();

        // Operand packing is {d3,d2,d1,d0}.
        do_sort(1'b0, "mixed",   16'h1739, 16'h9731, 3'd5);
        do_sort(1'b0, "reverse", 16'h05AF, 16'hFA50, 3'd6);
        do_sort(1'b0, "sorted",  16'hFA50, 16'hFA50, 3'd0);
        do_sort(1'b0, "equal",   16'h5555, 16'h5555, 3'd0);
        do_sort(1'b0, "dups",    16'h2424, 16'h4422, 3'd3);
        do_sort(1'b1, "desc",    16'h9731, 16'h1379, 3'd6);

        // Start while busy: only cycle-0 operands are sorted.
        start_a = 1'b1; din_a = 16'h1739;
        next_cycle();
        for (int c = 1; c <= 6; c++) begin
            start_a = (c == 3) ? 1'b1 : 1'b0;
            din_a   = 16'h0123 + 16'(c);
            check("busy_ign_done", {15'd0, done_a}, 16'd0);
            next_cycle();
        end
        start_a = 1'b1; din_a = 16'hFFFF;
        check("busy_ign_done7", {15'd0, done_a}, 16'd1);
        check("busy_ign_dout",  dout_a, 16'h9731);
        check("busy_ign_swaps", {13'd0, swap_a}, 16'd5);
        next_cycle();
        check("busy_ign_idle8", {15'd0, busy_a}, 16'd0);
        start_a = 1'b1; din_a = 16'h3012;
        next_cycle();
        start_a = 1'b0; din_a = 16'h0000;
        for (int c = 9; c <= 14; c++) begin
            check("c8_done_early", {15'd0, done_a}, 16'd0);
            next_cycle();
        end
        check("c8_done15", {15'd0, done_a}, 16'd1);
        check("c8_dout",   dout_a, 16'h3210);
        check("c8_swaps",  {13'd0, swap_a}, 16'd3);
        next_cycle();

        // Reset mid-sort at cycle 4, checked without any clock edge.
        start_a = 1'b1; din_a = 16'h1739;
        next_cycle();
        start_a = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        check("mid_busy_pre", {15'd0, busy_a}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dout",  dout_a, 16'h0000);
        check("mid_rst_busy",  {15'd0, busy_a}, 16'd0);
        check("mid_rst_done",  {15'd0, done_a}, 16'd0);
        check("mid_rst_swaps", {13'd0, swap_a}, 16'd0);
        #1;
        rst_n = 1'b1;
        do_sort(1'b0, "post_rst", 16'h3012, 16'h3210, 3'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sort4_ctrl.md
# sort4_ctrl

Sequenced four-entry sorter built around one shared magnitude comparator, the same greater/lesser/equal comparison our 4-bit comparator provides. An FSM loads four operands on a start request and runs a fixed 6-step compare-exchange schedule, one comparison per clock. It then presents the ordered result with a one-cycle done pulse. It sits between an operand source and any consumer that needs min/max or rank order, without instantiating six parallel comparators.

## Interface
- WIDTH, 4, bit width of each element.
- DESCEND, 0, sort order: 0 = ascending (element 0 smallest); 1 = descending (element 0 largest).

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load request; sampled only in IDLE.
- din  in  4*WIDTH  packed operands {d3,d2,d1,d0}; d0 occupies din[WIDTH-1:0].
- dout  out  4*WIDTH  packed working/result registers, same packing as din.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; dout holds the final order while done is high.
- swap_cnt  out  3  number of exchanges performed in the current or last sort, range 0..6.

## Operation
- Reset state:
  - FSM in IDLE.
  - dout = 0, busy = 0, done = 0, swap_cnt = 0, step = 0.
- States:
  - IDLE: if start = 1, load r0..r3 from din, clear swap_cnt and step, then go to CMP. If start = 0, hold every register.
  - CMP: one compare-exchange per cycle on pair (i, i+1). The schedule for step 0..5 is (0,1),(1,2),(2,3),(0,1),(1,2),(0,1). After step 5, go to DONE; otherwise increment step.
  - DONE: done = 1 for exactly one cycle, then return to IDLE.
- Exchange rule:
  - Ascending: swap when r[i] > r[i+1].
  - Descending: swap when r[i] < r[i+1].
  - Equal values never swap, so the sort is stable.
  - Each swap increments swap_cnt by 1.
- Comparison is unsigned and WIDTH bits wide, with no extension.
- One comparator instance only. A multiplexer selects the pair addressed by step; no per-pair comparators.
- start is ignored in CMP and DONE. There is no queuing and a dropped request raises no error.
- dout reflects the working registers at all times. Intermediate values are visible during CMP and are defined as valid only while done = 1 and afterwards in IDLE.
- dout and swap_cnt hold after DONE until the next accepted start.
- Reset mid-operation: asserting rst_n low immediately forces all outputs and state to their reset values, regardless of state. No partial result is retained.

## Timing
- Cycle 0: start = 1 in IDLE. Operands are captured at the end of cycle 0.
- Cycles 1–6: CMP steps 0–5. busy = 1.
- Cycle 7: DONE. done = 1, busy = 1, final dout and swap_cnt valid.
- Cycle 8: IDLE. busy = 0, and start is accepted again.
- Latency is 7 cycles from start to done; the minimum start-to-start interval is 8 cycles.
- busy is registered and rises in the cycle after start.
- start held high continuously produces one sort per 8 cycles.
- rst_n deassertion: the first start is accepted on the first rising edge with rst_n = 1 and start = 1.

## Test plan
- Mixed order, ascending: d0..d3 = 9,3,7,1 → dout elements 1,3,7,9; swap_cnt = 5; done in cycle 7 only.
- Reverse input: d0..d3 = 15,10,5,0 → 0,5,10,15 with swap_cnt = 6. The same input already sorted, 0,5,10,15 → unchanged, swap_cnt = 0.
- All equal and duplicates:
  - 5,5,5,5 → 5,5,5,5, swap_cnt = 0.
  - 4,2,4,2 → 2,2,4,4, swap_cnt = 3.
- DESCEND = 1: d0..d3 = 1,3,7,9 → 9,7,3,1, swap_cnt = 6.
- Start while busy: start pulses in cycles 0, 3 and 7 with new din values each time → only the cycle-0 operands are sorted. The next sort starts only from a cycle-8 start, and done appears at cycle 15.
- Reset mid-sort: assert rst_n low in cycle 4 → dout, busy, done and swap_cnt read 0 immediately with no clock edge. After release, start with 2,1,0,3 → 0,1,2,3, swap_cnt = 3.
